fwd_hazard_ctrl: RTL

Producer side of the execute-stage operand-forwarding interface. Tracks destination-register metadata for instructions in the X, M and W stages. Emits a registered 4-bit forward-select code that the X-stage operand mux consumes, aligned with the instruction currently in X. Also detects load-use hazards, which cost a one-cycle D stall plus an X bubble, and squashes the D-stage instruction on a taken branch or jump.

---
 rtl/fwd_pkg.sv | 83 ++++++++
 rtl/fwd_inst_dec.sv | 36 +++
 rtl/fwd_hazard_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared types for the execute-stage forwarding / hazard controller:
// RV32 opcodes, the stage record, forward-select codes and FSM states.
package fwd_pkg;

   // Width of a register index inside a stage record.
   localparam int REG_BITS = 5;

   // Major opcodes (inst[6:0]).
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;

   // Forward-select codes consumed by the X-stage operand mux (A,B source).
   typedef enum logic [3:0] {
      FWD_NONE = 4'd0,   // none, none
      FWD_MM   = 4'd1,   // M, M
      FWD_WW   = 4'd2,   // W, W
      FWD_MN   = 4'd3,   // M, none
      FWD_NM   = 4'd4,   // none, M
      FWD_WN   = 4'd5,   // W, none
      FWD_NW   = 4'd8,   // none, W
      FWD_WM   = 4'd9,   // W, M
      FWD_MW   = 4'd10   // M, W
   } fwd_code_e;

   // Per-operand source.
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_M    = 2'd1,
      SRC_W    = 2'd2
   } src_e;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } fsm_e;

   // Destination/source metadata carried alongside an instruction.
   // An all-zero record is a bubble.
   typedef struct packed {
      logic                valid;
      logic                we;
      logic                load;
      logic [REG_BITS-1:0] rd;
      logic [REG_BITS-1:0] rs1;
      logic [REG_BITS-1:0] rs2;
      logic                use_rs1;
      logic                use_rs2;
   } stage_rec_t;

   // Pick the youngest usable producer for one operand. A load in M only
   // holds an address, so it is never a forwarding source.
   function automatic src_e pick_src(input logic use_rs,
                                     input logic [REG_BITS-1:0] rs,
                                     input stage_rec_t m,
                                     input stage_rec_t w);
      if (use_rs && m.valid && m.we && !m.load && (m.rd == rs)) return SRC_M;
      if (use_rs && w.valid && w.we && (w.rd == rs))            return SRC_W;
      return SRC_NONE;
   endfunction

   // Map the (A,B) source pair onto the mux code.
   function automatic fwd_code_e fwd_code(input src_e a, input src_e b);
      case ({a, b})
         {SRC_M,    SRC_M}:    return FWD_MM;
         {SRC_W,    SRC_W}:    return FWD_WW;
         {SRC_M,    SRC_NONE}: return FWD_MN;
         {SRC_NONE, SRC_M}:    return FWD_NM;
         {SRC_W,    SRC_NONE}: return FWD_WN;
         {SRC_NONE, SRC_W}:    return FWD_NW;
         {SRC_W,    SRC_M}:    return FWD_WM;
         {SRC_M,    SRC_W}:    return FWD_MW;
         default:              return FWD_NONE;
      endcase
   endfunction

endpackage

// File: rtl/fwd_inst_dec.sv
// Combinational decoder: D-stage instruction word to stage record.
// A non-valid instruction decodes to a bubble.
module fwd_inst_dec
   import fwd_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] inst,
   input  logic            valid,
   output stage_rec_t      rec
);

   logic [6:0] opcode;
   logic       unused_fields;

   assign opcode        = inst[6:0];
   assign unused_fields = ^{inst[XLEN-1:25], inst[14:12]};

   // Field extraction and register-usage rules.
   always_comb begin
      // NOTE: default every field first so no path leaves rec unassigned (no latch).
      rec = '0;
      if (valid) begin
         rec.valid   = 1'b1;
         rec.rd      = inst[11:7];
         rec.rs1     = inst[19:15];
         rec.rs2     = inst[24:20];
         rec.load    = (opcode == LOAD);
         rec.we      = (opcode inside {OP, OP_IMM, LOAD, JAL, JALR, LUI, AUIPC})
                       && (inst[11:7] != '0);
         rec.use_rs1 = !(opcode inside {LUI, AUIPC, JAL});
         rec.use_rs2 = (opcode inside {OP, STORE, BRANCH});
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Execute-stage forwarding and load-use hazard controller.
// Tracks X/M/W destination metadata, registers the forward-select code for
// the instruction entering X, stalls one cycle on load-use and squashes D
// on a taken branch/jump.
// Optional: define HAZARD_STATS_EN to add saturating stall/forward counters.
module fwd_hazard_ctrl
   import fwd_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int NREG_BITS = REG_BITS
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [XLEN-1:0]      inst_D_i,
   input  logic                 valid_D_i,
   input  logic                 br_taken_X_i,
   output logic [3:0]           opforward_o,
   output logic                 stall_o,
   output logic                 flush_D_o,
   output logic [NREG_BITS-1:0] rd_X_o
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]          stall_cnt_o,
   output logic [31:0]          fwd_cnt_o
`endif
);

   stage_rec_t rec_d;
   stage_rec_t rec_x;
   stage_rec_t rec_m;
   stage_rec_t rec_w;
   stage_rec_t rec_x_nxt;
   fwd_code_e  fwd_nxt;
   fsm_e       state;
   fsm_e       state_nxt;
   logic       load_use;
   logic       unused_rec_w;

   fwd_inst_dec #(.XLEN(XLEN)) u_dec (
      .inst  (inst_D_i),
      .valid (valid_D_i),
      .rec   (rec_d)
   );

   // W is kept for visibility; forwarding reads W' (= current M) instead.
   assign unused_rec_w = ^rec_w;
   assign flush_D_o    = br_taken_X_i;
   assign rd_X_o       = NREG_BITS'(rec_x.rd);

   // Load in X whose result the D instruction needs this cycle.
   always_comb begin
      load_use = rec_x.valid && rec_x.load && rec_x.we && rec_d.valid &&
                 ((rec_d.use_rs1 && (rec_d.rs1 == rec_x.rd)) ||
                  (rec_d.use_rs2 && (rec_d.rs2 == rec_x.rd)));
   end

   // Next X record and the forward code it will need (M' = X, W' = M).
   always_comb begin
      rec_x_nxt = (stall_o || br_taken_X_i) ? '0 : rec_d;
      fwd_nxt   = fwd_code(pick_src(rec_x_nxt.use_rs1, rec_x_nxt.rs1, rec_x, rec_m),
                           pick_src(rec_x_nxt.use_rs2, rec_x_nxt.rs2, rec_x, rec_m));
   end

   // Pipeline records and registered forward code.
   always_ff @(posedge clk_i) begin
      // NOTE: the three records are plain registers, not a memory, so all are cleared on reset.
      if (rst_i) begin
         rec_x       <= '0;
         rec_m       <= '0;
         rec_w       <= '0;
         opforward_o <= FWD_NONE;
      end else begin
         // NOTE: non-blocking so rec_m/rec_w capture the pre-edge values of rec_x/rec_m.
         rec_x       <= rec_x_nxt;
         rec_m       <= rec_x;
         rec_w       <= rec_m;
         opforward_o <= fwd_nxt;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= RUN;
      else       state <= state_nxt;
   end

   // FSM next state: one HOLD cycle per load-use; a taken branch wins.
   always_comb begin
      state_nxt = RUN;
      case (state)
         RUN:     state_nxt = (load_use && !br_taken_X_i) ? HOLD : RUN;
         HOLD:    state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // FSM outputs: stall only while RUN sees an unsquashed load-use.
   always_comb begin
      stall_o = (state == RUN) && load_use && !br_taken_X_i;
   end

`ifdef HAZARD_STATS_EN
   // Saturating event counters.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_o <= '0;
         fwd_cnt_o   <= '0;
      end else begin
         if (stall_o && (stall_cnt_o != '1))
            stall_cnt_o <= stall_cnt_o + 32'd1;
         if ((opforward_o != 4'd0) && (fwd_cnt_o != '1))
            fwd_cnt_o <= fwd_cnt_o + 32'd1;
      end
   end
`endif

endmodule
